// File: rtl/calc_core_arbiter.sv
// Round-robin arbiter sharing one calculadora_core between a UART requester (port 0)
// and a local front end (port 1), with a watchdog that aborts operations the core never finishes.
module calc_core_arbiter #(
    parameter int OPERAND_W      = 16,
    parameter int OP_W           = 3,
    parameter int RESULT_W       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [OPERAND_W-1:0] req0_operand,
    input  logic [OP_W-1:0]      req0_op,
    output logic                 req0_accept,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [RESULT_W-1:0]  rsp0_result,
    output logic                 rsp0_timeout,
    input  logic                 req1_valid,
    input  logic [OPERAND_W-1:0] req1_operand,
    input  logic [OP_W-1:0]      req1_op,
    output logic                 req1_accept,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [RESULT_W-1:0]  rsp1_result,
    output logic                 rsp1_timeout,
    output logic [OPERAND_W-1:0] core_operand_a,
    output logic [OP_W-1:0]      core_operation,
    output logic                 core_start,
    input  logic [RESULT_W-1:0]  core_result,
    input  logic                 core_ready,
    output logic                 busy,
    output logic                 grant_id,
    output logic [7:0]           timeout_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic            last_grant;
    logic            grant_sel;
    logic            do_grant, do_done, do_abort, rsp_take;
    logic [WD_W-1:0] wdog;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_sel  = last_grant;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_abort   = 1'b0;
        rsp_take   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    do_grant   = 1'b1;
                    grant_sel  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // A ready on the expiry cycle still counts as a normal completion.
                if (core_ready) begin
                    do_done    = 1'b1;
                    state_next = RESP;
                end else if (wdog == WD_LAST) begin
                    do_abort   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (grant_id ? rsp1_ready : rsp0_ready) begin
                    rsp_take   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant     <= 1'b1;
            grant_id       <= 1'b0;
            busy           <= 1'b0;
            wdog           <= '0;
            timeout_count  <= 8'd0;
            core_operand_a <= '0;
            core_operation <= '0;
            core_start     <= 1'b0;
            req0_accept    <= 1'b0;
            req1_accept    <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp0_result    <= '0;
            rsp0_timeout   <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp1_result    <= '0;
            rsp1_timeout   <= 1'b0;
        end else begin
            busy        <= (state_next != IDLE);
            core_start  <= 1'b0;
            req0_accept <= 1'b0;
            req1_accept <= 1'b0;

            if (do_grant) begin
                grant_id       <= grant_sel;
                last_grant     <= grant_sel;
                core_operand_a <= grant_sel ? req1_operand : req0_operand;
                core_operation <= grant_sel ? req1_op : req0_op;
                core_start     <= 1'b1;
                req0_accept    <= ~grant_sel;
                req1_accept    <= grant_sel;
            end

            if (state == ISSUE)     wdog <= '0;
            else if (state == WAIT) wdog <= wdog + 1'b1;

            if (do_done || do_abort) begin
                if (grant_id) begin
                    rsp1_valid   <= 1'b1;
                    rsp1_result  <= do_done ? core_result : '0;
                    rsp1_timeout <= do_abort;
                end else begin
                    rsp0_valid   <= 1'b1;
                    rsp0_result  <= do_done ? core_result : '0;
                    rsp0_timeout <= do_abort;
                end
            end

            if (do_abort) timeout_count <= sat_inc(timeout_count);

            // Clearing the whole response keeps the idle port's rsp outputs at zero.
            if (rsp_take) begin
                if (grant_id) begin
                    rsp1_valid   <= 1'b0;
                    rsp1_result  <= '0;
                    rsp1_timeout <= 1'b0;
                end else begin
                    rsp0_valid   <= 1'b0;
                    rsp0_result  <= '0;
                    rsp0_timeout <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_core_arbiter.sv
// Directed bench for calc_core_arbiter: the bench plays the core and both requesters.
module tb_calc_core_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_operand, req1_operand;
    logic [2:0]  req0_op, req1_op;
    logic        req0_accept, req1_accept;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_timeout, rsp1_timeout;
    logic [15:0] core_operand_a;
    logic [2:0]  core_operation;
    logic        core_start;
    logic [31:0] core_result;
    logic        core_ready;
    logic        busy;
    logic        grant_id;
    logic [7:0]  timeout_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_tc   = 0;

    calc_core_arbiter #(
        .OPERAND_W(16), .OP_W(3), .RESULT_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_operand(req0_operand), .req0_op(req0_op),
        .req0_accept(req0_accept), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_timeout(rsp0_timeout),
        .req1_valid(req1_valid), .req1_operand(req1_operand), .req1_op(req1_op),
        .req1_accept(req1_accept), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_timeout(rsp1_timeout),
        .core_operand_a(core_operand_a), .core_operation(core_operation),
        .core_start(core_start), .core_result(core_result), .core_ready(core_ready),
        .busy(busy), .grant_id(grant_id), .timeout_count(timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_grant"},   32'(grant_id), 0);
        check({tag, "_start"},   32'(core_start), 0);
        check({tag, "_operand"}, 32'(core_operand_a), 0);
        check({tag, "_op"},      32'(core_operation), 0);
        check({tag, "_acc"},     32'({req1_accept, req0_accept}), 0);
        check({tag, "_rspv"},    32'({rsp1_valid, rsp0_valid}), 0);
        check({tag, "_rspt"},    32'({rsp1_timeout, rsp0_timeout}), 0);
        check({tag, "_res0"},    rsp0_result, 0);
        check({tag, "_res1"},    rsp1_result, 0);
        check({tag, "_tcount"},  32'(timeout_count), 0);
    endtask

    // Called at the negedge where the request is (or has been) pending in IDLE.
    // lat = cycles after the start cycle at which core_ready pulses; 0 = never.
    task automatic serve(input int port, input logic [15:0] opnd, input logic [2:0] op,
                         input int lat, input logic [31:0] res, input bit stale, input int hold);
        int n;
        int wait_n;
        logic [31:0] exp_res;
        bit tmo;
        n = 0;
        while (!(port != 0 ? req1_accept : req0_accept) && n < 20) begin
            tick();
            n++;
        end
        check("accept_delay", n, 1);
        check("start_with_accept", 32'(core_start), 1);
        check("other_accept", 32'(port != 0 ? req0_accept : req1_accept), 0);
        check("grant_id", 32'(grant_id), port);
        check("core_operand", 32'(core_operand_a), 32'(opnd));
        check("core_op", 32'(core_operation), 32'(op));
        if (port != 0) req1_valid = 1'b0; else req0_valid = 1'b0;
        core_ready  = stale;
        core_result = 32'hDEAD_BEEF;
        wait_n = (lat == 0) ? TO : lat;
        for (int i = 0; i < wait_n; i++) begin
            tick();
            core_ready = 1'b0;
        end
        check("rsp_early", 32'(port != 0 ? rsp1_valid : rsp0_valid), 0);
        check("start_pulse", 32'(core_start), 0);
        if (lat != 0) begin
            core_ready  = 1'b1;
            core_result = res;
        end
        tick();
        core_ready  = 1'b0;
        core_result = 32'h0BAD_0BAD;
        tmo = (lat == 0);
        exp_res = tmo ? 32'h0 : res;
        if (tmo && exp_tc != 255) exp_tc++;
        check("rsp_valid", 32'(port != 0 ? rsp1_valid : rsp0_valid), 1);
        check("rsp_result", port != 0 ? rsp1_result : rsp0_result, exp_res);
        check("rsp_timeout", 32'(port != 0 ? rsp1_timeout : rsp0_timeout), 32'(tmo));
        check("other_rsp_valid", 32'(port != 0 ? rsp0_valid : rsp1_valid), 0);
        check("other_rsp_result", port != 0 ? rsp0_result : rsp1_result, 0);
        check("busy_resp", 32'(busy), 1);
        check("timeout_count", 32'(timeout_count), exp_tc);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(port != 0 ? rsp1_valid : rsp0_valid), 1);
            check("hold_result", port != 0 ? rsp1_result : rsp0_result, exp_res);
            check("hold_busy", 32'(busy), 1);
            check("hold_no_accept", 32'({req1_accept, req0_accept}), 0);
        end
        if (port != 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("rsp_cleared", 32'(port != 0 ? rsp1_valid : rsp0_valid), 0);
        check("rsp_result_cleared", port != 0 ? rsp1_result : rsp0_result, 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req0_valid = 1'b0; req0_operand = '0; req0_op = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_operand = '0; req1_op = '0; rsp1_ready = 1'b0;
        core_result = '0; core_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_cleared("reset");

        // Single request on port 0.
        req0_operand = 16'h0012; req0_op = 3'd3; req0_valid = 1'b1;
        serve(0, 16'h0012, 3'd3, 4, 32'h0000_0024, 1'b0, 0);

        // Both valid from reset: 0, then 1, then 0 again.
        reset = 1'b1;
        req0_operand = 16'h1111; req0_op = 3'd1; req0_valid = 1'b1;
        req1_operand = 16'h2222; req1_op = 3'd2; req1_valid = 1'b1;
        tick();
        reset = 1'b0;
        serve(0, 16'h1111, 3'd1, 2, 32'h0000_1234, 1'b0, 0);
        serve(1, 16'h2222, 3'd2, 1, 32'hCAFE_0001, 1'b0, 0);
        req0_operand = 16'h3333; req0_op = 3'd4; req0_valid = 1'b1;
        req1_operand = 16'h4444; req1_op = 3'd5; req1_valid = 1'b1;
        serve(0, 16'h3333, 3'd4, 3, 32'h8000_0000, 1'b0, 0);
        serve(1, 16'h4444, 3'd5, 2, 32'hFFFF_FFFF, 1'b0, 0);

        // Backpressure on port 1 with port 0 pending behind it.
        req0_operand = 16'h0005; req0_op = 3'd6; req0_valid = 1'b1;
        serve(0, 16'h0005, 3'd6, 1, 32'h0000_0050, 1'b0, 0);
        req0_operand = 16'h0A0A; req0_op = 3'd7; req0_valid = 1'b1;
        req1_operand = 16'hB0B0; req1_op = 3'd0; req1_valid = 1'b1;
        serve(1, 16'hB0B0, 3'd0, 3, 32'h1357_9BDF, 1'b0, 10);
        serve(0, 16'h0A0A, 3'd7, 2, 32'h2468_ACE0, 1'b0, 0);

        // Watchdog abort, then a stray ready while idle.
        req0_operand = 16'h00FF; req0_op = 3'd2; req0_valid = 1'b1;
        serve(0, 16'h00FF, 3'd2, 0, 32'h0, 1'b0, 0);
        core_ready = 1'b1; core_result = 32'h7777_7777;
        tick();
        core_ready = 1'b0;
        check("late_ready_busy", 32'(busy), 0);
        check("late_ready_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        check("late_ready_start", 32'(core_start), 0);
        check("late_ready_tcount", 32'(timeout_count), 1);

        // Stale ready in ISSUE, then ready exactly on the expiry cycle.
        req1_operand = 16'h0101; req1_op = 3'd1; req1_valid = 1'b1;
        serve(1, 16'h0101, 3'd1, 3, 32'h0000_0202, 1'b1, 0);
        req0_operand = 16'h0303; req0_op = 3'd3; req0_valid = 1'b1;
        serve(0, 16'h0303, 3'd3, TO, 32'h0000_0909, 1'b0, 0);

        // Reset in the middle of WAIT.
        req1_operand = 16'h5A5A; req1_op = 3'd4; req1_valid = 1'b1;
        n = 0;
        while (!req1_accept && n < 20) begin
            tick();
            n++;
        end
        check("midwait_accept", 32'(req1_accept), 1);
        req1_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_tc = 0;
        check_cleared("midwait_reset");
        core_ready = 1'b1; core_result = 32'h9999_9999;
        tick();
        core_ready = 1'b0;
        check("midwait_no_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        check("midwait_idle", 32'(busy), 0);
        req1_operand = 16'h6B6B; req1_op = 3'd5; req1_valid = 1'b1;
        serve(1, 16'h6B6B, 3'd5, 2, 32'h00AB_CDEF, 1'b0, 0);

        // Saturating abort counter.
        for (int i = 0; i < 260; i++) begin
            req0_operand = 16'(i); req0_op = 3'(i); req0_valid = 1'b1;
            serve(0, 16'(i), 3'(i), 0, 32'h0, 1'b0, 0);
        end
        check("tcount_saturated", 32'(timeout_count), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
